// File: rtl/serial_shift_rx.sv
// Serial shift-chain receiver: synchronizes s_clk/s_sout/s_pen/s_clrn into clk, deserializes, checks frame length.
// Optional SERIAL_SHIFT_RX_FRAMECNT_EN adds frame_cnt (good frames) and err_cnt (length errors).
module serial_shift_rx #(
  parameter int WIDTH     = 64,
  parameter int CNT_W     = 7,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_clk,
  input  logic             s_sout,
  input  logic             s_pen,
  input  logic             s_clrn,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic [CNT_W-1:0] bit_cnt
`ifdef SERIAL_SHIFT_RX_FRAMECNT_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t           state_q, state_d;
  logic [2:0]       clk_sr, pen_sr;
  logic [1:0]       sout_sr, clrn_sr;
  logic [WIDTH-1:0] sr_q, sr_d, dout_d;
  logic [CNT_W-1:0] cnt_d, cnt_inc;
  logic             dv_d, err_d;
  logic             clk_rise, pen_rise, pen_fall, pen_low, sout_bit, clr;

  // Index 1 is the synchronized level, index 2 the previous one for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sr  <= 3'b000;
      pen_sr  <= 3'b111;
      sout_sr <= 2'b00;
      clrn_sr <= 2'b11;
    end else begin
      clk_sr  <= {clk_sr[1:0], s_clk};
      pen_sr  <= {pen_sr[1:0], s_pen};
      sout_sr <= {sout_sr[0], s_sout};
      clrn_sr <= {clrn_sr[0], s_clrn};
    end
  end

  assign clk_rise = clk_sr[1] & ~clk_sr[2];
  assign pen_rise = pen_sr[1] & ~pen_sr[2];
  assign pen_fall = ~pen_sr[1] & pen_sr[2];
  assign pen_low  = ~pen_sr[1];
  assign sout_bit = sout_sr[1];
  assign clr      = ~clrn_sr[1];
  assign cnt_inc  = (bit_cnt == {CNT_W{1'b1}}) ? bit_cnt : bit_cnt + CNT_W'(1);

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr, input logic b);
    if (MSB_FIRST) return {sr[WIDTH-2:0], b};
    else           return {b, sr[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = bit_cnt;
    dout_d  = data_out;
    dv_d    = 1'b0;
    err_d   = frame_err;
    if (clr) begin
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = '0;
      dout_d  = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pen_fall || (clk_rise && pen_low)) begin
            state_d = SHIFT;
            sr_d    = '0;
            cnt_d   = '0;
            if (clk_rise) begin
              sr_d  = shift_in('0, sout_bit);
              cnt_d = CNT_W'(1);
            end
          end
        end
        SHIFT: begin
          // A bit arriving with the closing strobe is shifted before the count check.
          if (clk_rise) begin
            sr_d  = shift_in(sr_q, sout_bit);
            cnt_d = cnt_inc;
          end
          if (pen_rise) state_d = LATCH;
        end
        LATCH: begin
          state_d = IDLE;
          if (bit_cnt == CNT_W'(WIDTH)) begin
            dout_d = sr_q;
            dv_d   = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt    <= cnt_d;
      data_out   <= dout_d;
      data_valid <= dv_d;
      frame_err  <= err_d;
    end
  end

`ifdef SERIAL_SHIFT_RX_FRAMECNT_EN
  logic len_err;
  assign len_err = ~clr && (state_q == LATCH) && (bit_cnt != CNT_W'(WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (clr) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (dv_d) frame_cnt <= frame_cnt + 16'd1;
      if (len_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/serial_shift_rx.md
Name: serial_shift_rx

Overview:
- Receiver and capture end of the board's serial display/LED shift interface (clock, serial data, PEN strobe, clear-n), as driven by the seven-segment and LED serial output devices.
- Deserializes the shifted stream into a parallel word in the system clock domain, checks the frame length, and presents the result for loopback self-test, simulation scoreboarding, or readback on the MIO bus.
- Instantiated twice: WIDTH=64 for the segment chain, WIDTH=16 for the LED chain.

Parameters:
- WIDTH, 64, bits per frame, 2..64
- CNT_W, 7, bit-counter width; must satisfy 2^CNT_W > WIDTH
- MSB_FIRST, 1, 1: first shifted bit lands in data_out[WIDTH-1]; 0: first bit lands in data_out[0]

Ports:
- clk  input  1  system clock (clk_100MHz domain)
- rst  input  1  asynchronous reset, active-high
- s_clk  input  1  serial shift clock from transmitter; asynchronous to clk
- s_sout  input  1  serial data; sampled on s_clk rising edge
- s_pen  input  1  transmitter latch/enable; low while shifting, rising edge ends frame
- s_clrn  input  1  active-low clear from transmitter
- data_out  output  WIDTH  last good frame
- data_valid  output  1  one-clk pulse when data_out updates
- frame_err  output  1  sticky; set on wrong bit count
- bit_cnt  output  CNT_W  bits received in current frame, saturating

Behaviour:
- Sync: s_clk, s_sout, s_pen and s_clrn each pass through 2-flop synchronizers in the clk domain.
- Edge detect: a third register per signal detects edges. An s_clk rising edge is acted on 3 clk after the pin edge.
- Timing constraint: the transmitter's s_clk high and low times must each be at least 3 clk. Faster streams are out of spec.
- Reset: data_out=0, data_valid=0, frame_err=0, bit_cnt=0, shift register=0, state=IDLE.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE:
  - s_pen falling edge -> SHIFT, clear bit_cnt and shift register.
  - s_clk rising edge while s_pen is low also -> SHIFT, and captures that first bit.
- SHIFT:
  - Each s_clk rising edge shifts in the synchronized s_sout.
  - MSB_FIRST=1: shift left, new bit at bit 0. MSB_FIRST=0: shift right, new bit at bit WIDTH-1.
  - bit_cnt increments and saturates at 2^CNT_W-1. Bits beyond WIDTH still shift, so the oldest bits drop.
  - s_pen rising edge -> LATCH.
- LATCH (one clk):
  - bit_cnt==WIDTH: data_out <= shift register, data_valid=1 for this clk.
  - Otherwise: frame_err <= 1 and data_out is unchanged.
  - Then -> IDLE; bit_cnt holds its value until the next frame starts.
- s_clrn low (synchronized level), any state: shift register=0, bit_cnt=0, data_out=0, frame_err=0, state=IDLE. No data_valid pulse.
- Simultaneous events:
  - s_clk rising and s_pen rising in the same clk: the bit is shifted first, then the count is checked in LATCH.
  - s_clrn overrides everything.
- s_pen rising edge in IDLE with no bits received: ignored, no error.
- frame_err clears only on rst or s_clrn.
- Reset asserted mid-frame: the frame is abandoned; the next frame starts fresh on the next s_pen falling edge.

Optional Feature:
- Macro: SERIAL_SHIFT_RX_FRAMECNT_EN
- Defined: adds output frame_cnt [15:0].
  - Increments on every data_valid and wraps 0xFFFF->0.
  - Cleared by rst or s_clrn.
  - Adds output err_cnt [7:0], which increments on each length error and saturates at 0xFF.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- WIDTH=16, MSB_FIRST=1, s_clk period 10 clk: s_pen low, shift 0xA5C3 MSB first, s_pen high -> data_out=0xA5C3, one data_valid pulse ~4 clk after s_pen rise, frame_err=0.
- WIDTH=64: shift 0x0123_4567_89AB_CDEF -> data_out matches exactly. Repeat with MSB_FIRST=0, stream sent LSB first -> same value.
- WIDTH=16: shift 15 bits, raise s_pen -> frame_err=1, data_out keeps prior 0xA5C3, no data_valid. Then a good 0x1234 frame -> data_out=0x1234, frame_err still 1.
- Pull s_clrn low for 5 clk mid-frame after 8 bits -> bit_cnt=0, data_out=0, frame_err=0. A following full frame of 0xFFFF is received correctly.
- Assert rst during bit 10 of a frame -> all outputs 0 immediately, asynchronously. After release, a full frame is captured normally.
- With SERIAL_SHIFT_RX_FRAMECNT_EN: send 3 good frames and 1 short frame -> frame_cnt=3, err_cnt=1. Preload frame_cnt to 0xFFFF via 65535 frames (or force) plus 1 good frame -> frame_cnt=0.
